// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared op encodings, mul/div FSM states and default width for the execute stage
package ex_pkg;

    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_XOR   = 5'd4,
        OP_NOR   = 5'd5,
        OP_SLT   = 5'd6,
        OP_SLTU  = 5'd7,
        OP_SLL   = 5'd8,
        OP_SRL   = 5'd9,
        OP_SRA   = 5'd10,
        OP_MFHI  = 5'd11,
        OP_MFLO  = 5'd12,
        OP_LUI   = 5'd13,
        OP_MULT  = 5'd14,
        OP_MULTU = 5'd15,
        OP_DIV   = 5'd16,
        OP_DIVU  = 5'd17,
        OP_MTHI  = 5'd18,
        OP_MTLO  = 5'd19
    } op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Ops that read or write Hi/Lo and therefore must wait for the iterative unit.
    function automatic logic is_hilo_op(input op_e op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                          OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
    endfunction

    function automatic logic writes_gpr(input op_e op);
        return !(op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO});
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative shift-add multiplier and restoring divider, one bit per cycle
module mul_div_unit
    import ex_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);

    logic                active;
    logic [CNT_W-1:0]    count;
    logic                is_div;
    logic                neg_q;
    logic                neg_r;
    logic                div_zero;
    logic [DATA_W-1:0]   acc_hi;
    logic [DATA_W-1:0]   acc_lo;
    logic [DATA_W-1:0]   mag_b;
    logic [DATA_W-1:0]   dividend;

    logic                signed_op;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   mag_a_in;
    logic [DATA_W-1:0]   mag_b_in;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic                div_ok;
    logic [DATA_W-1:0]   hi_next;
    logic [DATA_W-1:0]   lo_next;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;

    // Signed ops run on magnitudes; the sign is restored on the final step.
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = signed_op & a[DATA_W-1];
        b_neg     = signed_op & b[DATA_W-1];
        mag_a_in  = a_neg ? -a : a;
        mag_b_in  = b_neg ? -b : b;
    end

    // acc_lo holds the multiplier (mul) or the dividend being shifted out (div).
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
        div_shift = {acc_hi, acc_lo[DATA_W-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        div_ok    = ~div_diff[DATA_W];
        if (is_div) begin
            hi_next = div_ok ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
            lo_next = {acc_lo[DATA_W-2:0], div_ok};
        end else begin
            hi_next = mul_sum[DATA_W:1];
            lo_next = {mul_sum[0], acc_lo[DATA_W-1:1]};
        end
    end

    always_comb begin
        prod = {hi_next, lo_next};
        if (neg_q) begin
            prod = -prod;
        end
        quo = neg_q ? -lo_next : lo_next;
        rem = neg_r ? -hi_next : hi_next;
        if (!is_div) begin
            hi = prod[2*DATA_W-1:DATA_W];
            lo = prod[DATA_W-1:0];
        end else if (div_zero) begin
            hi = dividend;
            lo = '1;
        end else begin
            hi = rem;
            lo = quo;
        end
    end

    assign done = active && (count == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            mag_b    <= '0;
            dividend <= '0;
        end else if (start) begin
            active   <= 1'b1;
            count    <= '0;
            is_div   <= (op == OP_DIV) || (op == OP_DIVU);
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (b == '0);
            acc_hi   <= '0;
            acc_lo   <= mag_a_in;
            mag_b    <= mag_b_in;
            dividend <= a;
        end else if (active) begin
            acc_hi <= hi_next;
            acc_lo <= lo_next;
            count  <= count + CNT_W'(1);
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_stage_multicycle.sv
// rtl/exec_stage_multicycle.sv - execute stage: forwarding muxes, ALU, Hi/Lo and iterative mul/div
// Define EX_DIV_EN to enable DIV/DIVU; otherwise they retire as single-cycle no-ops.
module exec_stage_multicycle
    import ex_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NUM_FW = 4
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       InValid,
    input  logic                       Flush,
    input  op_e                        Op,
    input  logic                       ALUSrc,
    input  logic                       RegWrite_In,
    input  logic [1:0]                 RegDestSel,
    input  logic [31:0]                Instruction,
    input  logic [NUM_FW*DATA_W-1:0]   FWData,
    input  logic [$clog2(NUM_FW)-1:0]  FWSelA,
    input  logic [$clog2(NUM_FW)-1:0]  FWSelB,
    input  logic [DATA_W-1:0]          SE_In,
    output logic [DATA_W-1:0]          ALUResult,
    output logic [DATA_W-1:0]          FWMuxB_Out,
    output logic [4:0]                 RegDest,
    output logic                       RegWrite_Out,
    output logic                       OutValid,
    output logic                       Stall,
    output logic                       MDBusy
);

    logic [DATA_W-1:0] fw [NUM_FW];
    md_state_e         state;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] md_hi;
    logic [DATA_W-1:0] md_lo;
    logic [4:0]        shamt;
    logic              md_op;
    logic              md_start;
    logic              md_done;
    logic              unused_instr;

    for (genvar i = 0; i < NUM_FW; i++) begin : g_fw
        assign fw[i] = FWData[i*DATA_W +: DATA_W];
    end

    assign op_a       = fw[FWSelA];
    assign FWMuxB_Out = fw[FWSelB];
    assign op_b       = ALUSrc ? SE_In : FWMuxB_Out;
    assign shamt      = Instruction[10:6] & 5'(DATA_W - 1);

    assign unused_instr = &{1'b0, Instruction[31:21], Instruction[5:0]};

    always_comb begin
        ALUResult = '0;
        case (Op)
            OP_ADD:  ALUResult = op_a + op_b;
            OP_SUB:  ALUResult = op_a - op_b;
            OP_AND:  ALUResult = op_a & op_b;
            OP_OR:   ALUResult = op_a | op_b;
            OP_XOR:  ALUResult = op_a ^ op_b;
            OP_NOR:  ALUResult = ~(op_a | op_b);
            OP_SLT:  ALUResult = DATA_W'($signed(op_a) < $signed(op_b));
            OP_SLTU: ALUResult = DATA_W'(op_a < op_b);
            OP_SLL:  ALUResult = op_b << shamt;
            OP_SRL:  ALUResult = op_b >> shamt;
            OP_SRA:  ALUResult = $unsigned($signed(op_b) >>> shamt);
            OP_MFHI: ALUResult = hi_q;
            OP_MFLO: ALUResult = lo_q;
            OP_LUI:  ALUResult = op_b << 16;
            default: ALUResult = '0;
        endcase
    end

    always_comb begin
        RegDest = 5'd0;
        case (RegDestSel)
            2'd0:    RegDest = Instruction[15:11];
            2'd1:    RegDest = Instruction[20:16];
            2'd2:    RegDest = 5'd31;
            default: RegDest = 5'd0;
        endcase
    end

`ifdef EX_DIV_EN
    assign md_op = Op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
`else
    assign md_op = Op inside {OP_MULT, OP_MULTU};
`endif

    assign MDBusy       = (state == MD_BUSY);
    assign Stall        = InValid & MDBusy & is_hilo_op(Op);
    assign OutValid     = InValid & ~Stall & ~Flush;
    assign RegWrite_Out = RegWrite_In & OutValid & writes_gpr(Op);
    assign md_start     = OutValid & (state == MD_IDLE) & md_op;

    mul_div_unit #(
        .DATA_W (DATA_W)
    ) u_mul_div (
        .clk   (Clock),
        .rst   (Reset),
        .start (md_start),
        .op    (Op),
        .a     (op_a),
        .b     (op_b),
        .done  (md_done),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    // Hi/Lo moves are only accepted while idle; in BUSY they stall instead.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= MD_IDLE;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (md_start) begin
                        state <= MD_BUSY;
                    end else if (OutValid && Op == OP_MTHI) begin
                        hi_q <= op_a;
                    end else if (OutValid && Op == OP_MTLO) begin
                        lo_q <= op_a;
                    end
                end
                MD_BUSY: begin
                    if (md_done) begin
                        hi_q  <= md_hi;
                        lo_q  <= md_lo;
                        state <= MD_IDLE;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_stage_multicycle.sv
// tb/tb_exec_stage_multicycle.sv - directed scoreboard bench for exec_stage_multicycle
module tb_exec_stage_multicycle;
    import ex_pkg::*;

    localparam int W  = 32;
    localparam int NF = 4;

    localparam int S_RES  = 0;
    localparam int S_RW   = 1;
    localparam int S_RD   = 2;
    localparam int S_OV   = 3;
    localparam int S_ST   = 4;
    localparam int S_BUSY = 5;
    localparam int S_FWB  = 6;

    logic            Clock = 1'b0;
    logic            Reset;
    logic            InValid;
    logic            Flush;
    op_e             Op;
    logic            ALUSrc;
    logic            RegWrite_In;
    logic [1:0]      RegDestSel;
    logic [31:0]     Instruction;
    logic [NF*W-1:0] FWData;
    logic [1:0]      FWSelA;
    logic [1:0]      FWSelB;
    logic [W-1:0]    SE_In;
    logic [W-1:0]    ALUResult;
    logic [W-1:0]    FWMuxB_Out;
    logic [4:0]      RegDest;
    logic            RegWrite_Out;
    logic            OutValid;
    logic            Stall;
    logic            MDBusy;

    exec_stage_multicycle #(.DATA_W(W), .NUM_FW(NF)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .InValid      (InValid),
        .Flush        (Flush),
        .Op           (Op),
        .ALUSrc       (ALUSrc),
        .RegWrite_In  (RegWrite_In),
        .RegDestSel   (RegDestSel),
        .Instruction  (Instruction),
        .FWData       (FWData),
        .FWSelA       (FWSelA),
        .FWSelB       (FWSelB),
        .SE_In        (SE_In),
        .ALUResult    (ALUResult),
        .FWMuxB_Out   (FWMuxB_Out),
        .RegDest      (RegDest),
        .RegWrite_Out (RegWrite_Out),
        .OutValid     (OutValid),
        .Stall        (Stall),
        .MDBusy       (MDBusy)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string        tag;
        int           sel;
        logic [W-1:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [W-1:0] observe(input int sel);
        case (sel)
            S_RES:   return ALUResult;
            S_RW:    return W'(RegWrite_Out);
            S_RD:    return W'(RegDest);
            S_OV:    return W'(OutValid);
            S_ST:    return W'(Stall);
            S_BUSY:  return W'(MDBusy);
            default: return FWMuxB_Out;
        endcase
    endfunction

    task automatic check_now(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int sel, input logic [W-1:0] exp);
        sb.push_back('{tag, sel, exp});
    endtask

    task automatic check_pending();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_now(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic cycle();
        @(negedge Clock);
        check_pending();
        @(posedge Clock);
        #1;
    endtask

    // Returns at the negedge of the first cycle in which the held instruction is not stalled.
    task automatic wait_accept(output int stalls);
        stalls = 0;
        @(negedge Clock);
        while (Stall && stalls < 64) begin
            stalls++;
            @(negedge Clock);
        end
    endtask

    task automatic drive(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        InValid     = 1'b1;
        Flush       = 1'b0;
        Op          = op;
        ALUSrc      = 1'b0;
        RegWrite_In = 1'b1;
        RegDestSel  = 2'd0;
        FWSelA      = 2'd1;
        FWSelB      = 2'd2;
        FWData[1*W +: W] = a;
        FWData[2*W +: W] = b;
    endtask

    function automatic logic [W-1:0] alu_model(input op_e op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [4:0] sh);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_SLL:  return b << sh;
            OP_SRL:  return b >> sh;
            OP_SRA:  return $unsigned($signed(b) >>> sh);
            OP_LUI:  return {b[15:0], 16'h0000};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [4:0] dest_model(input logic [1:0] sel, input logic [31:0] instr);
        case (sel)
            2'd0:    return instr[15:11];
            2'd1:    return instr[20:16];
            2'd2:    return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_e          alu_ops [11];
        op_e          dir_ops [5];
        logic [W-1:0] dir_a [5];
        logic [W-1:0] dir_b [5];
        logic [4:0]   dir_sh [5];
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] opb;
        logic [W-1:0] imm;
        logic [W-1:0] lo_val;
        logic [63:0]  prod;
        op_e          o;
        int           stalls;

        alu_ops = '{OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
                    OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_LUI};
        dir_ops = '{OP_ADD, OP_SLT, OP_SLTU, OP_SRA, OP_SRL};
        dir_a   = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0};
        dir_b   = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000};
        dir_sh  = '{5'd0, 5'd0, 5'd0, 5'd31, 5'd31};

        Reset       = 1'b1;
        InValid     = 1'b1;
        Flush       = 1'b0;
        Op          = OP_MFHI;
        ALUSrc      = 1'b0;
        RegWrite_In = 1'b0;
        RegDestSel  = 2'd0;
        Instruction = 32'h0;
        FWData      = '0;
        FWSelA      = 2'd0;
        FWSelB      = 2'd0;
        SE_In       = '0;

        // Reset state
        #1;
        check_now("rst_mdbusy", W'(MDBusy), 0);
        check_now("rst_stall", W'(Stall), 0);
        check_now("rst_hi", ALUResult, 0);
        cycle();
        Reset = 1'b0;
        drive(OP_MFLO, 0, 0);
        push_exp("rst_lo", S_RES, 0);
        push_exp("rst_busy_after", S_BUSY, 0);
        cycle();

        // ADD 7 + (-3) through forwarding slots 2 and 0
        drive(OP_ADD, 0, 0);
        FWData[2*W +: W] = 32'd7;
        FWData[0*W +: W] = 32'hFFFF_FFFD;
        FWSelA = 2'd2;
        FWSelB = 2'd0;
        Instruction = (32'd9 << 16) | (32'd5 << 11);
        push_exp("add_res", S_RES, 32'd4);
        push_exp("add_rw", S_RW, 1);
        push_exp("add_rd", S_RD, 5);
        push_exp("add_ov", S_OV, 1);
        push_exp("add_fwb", S_FWB, 32'hFFFF_FFFD);
        cycle();

        // Directed boundaries: wrap, signed/unsigned compare, shift by 31
        for (int i = 0; i < 5; i++) begin
            drive(dir_ops[i], dir_a[i], dir_b[i]);
            Instruction = {21'h0, dir_sh[i], 6'h0};
            RegWrite_In = (i != 0);
            push_exp("bnd_res", S_RES, alu_model(dir_ops[i], dir_a[i], dir_b[i], dir_sh[i]));
            push_exp("bnd_rw", S_RW, W'(i != 0));
            cycle();
        end

        // Random single-cycle ops, immediates and destination selects
        for (int i = 0; i < 22; i++) begin
            o = alu_ops[i % 11];
            a = $urandom;
            b = $urandom;
            imm = $urandom;
            drive(o, a, b);
            Instruction = $urandom;
            ALUSrc = (i % 3 == 0);
            SE_In = imm;
            RegDestSel = 2'(i % 4);
            opb = ALUSrc ? imm : b;
            push_exp("alu_res", S_RES, alu_model(o, a, opb, Instruction[10:6]));
            push_exp("alu_rd", S_RD, W'(dest_model(RegDestSel, Instruction)));
            push_exp("alu_rw", S_RW, 1);
            push_exp("alu_fwb", S_FWB, b);
            cycle();
        end

        // MULT 0xFFFFFFFF * 2 signed, MFHI right behind it
        a = 32'hFFFF_FFFF;
        b = 32'h0000_0002;
        prod = 64'(signed'(a)) * 64'(signed'(b));
        drive(OP_MULT, a, b);
        push_exp("mult_ov", S_OV, 1);
        push_exp("mult_rw", S_RW, 0);
        push_exp("mult_idle", S_BUSY, 0);
        cycle();
        drive(OP_MFHI, 0, 0);
        wait_accept(stalls);
        check_now("mult_stalls", stalls, 32);
        push_exp("mult_hi", S_RES, prod[63:32]);
        push_exp("mfhi_rw", S_RW, 1);
        check_pending();
        @(posedge Clock);
        #1;
        drive(OP_MFLO, 0, 0);
        push_exp("mult_lo", S_RES, prod[31:0]);
        push_exp("mult_done", S_BUSY, 0);
        cycle();

        // MULTU in flight: ALU ops proceed, MTLO waits for IDLE
        a = $urandom | 32'h8000_0001;
        b = $urandom | 32'h8000_0000;
        prod = 64'(a) * 64'(b);
        drive(OP_MULTU, a, b);
        push_exp("multu_ov", S_OV, 1);
        cycle();
        a = $urandom;
        b = $urandom;
        drive(OP_ADD, a, b);
        push_exp("busy_add_stall", S_ST, 0);
        push_exp("busy_add_busy", S_BUSY, 1);
        push_exp("busy_add_res", S_RES, a + b);
        push_exp("busy_add_rw", S_RW, 1);
        cycle();
        drive(OP_SLL, a, b);
        Instruction = {21'h0, 5'd5, 6'h0};
        push_exp("busy_sll_stall", S_ST, 0);
        push_exp("busy_sll_res", S_RES, b << 5);
        cycle();
        lo_val = 32'h1234_5678;
        drive(OP_MTLO, lo_val, 0);
        push_exp("mtlo_stall0", S_ST, 1);
        push_exp("mtlo_ov0", S_OV, 0);
        @(negedge Clock);
        check_pending();
        wait_accept(stalls);
        check_now("mtlo_stalls", stalls + 1, 30);
        push_exp("mtlo_ov", S_OV, 1);
        push_exp("mtlo_rw", S_RW, 0);
        check_pending();
        @(posedge Clock);
        #1;
        drive(OP_MFHI, 0, 0);
        push_exp("multu_hi", S_RES, prod[63:32]);
        cycle();
        drive(OP_MFLO, 0, 0);
        push_exp("mtlo_lo", S_RES, lo_val);
        cycle();

        // Reset while BUSY at count 10
        drive(OP_MULT, 32'h7654_3210, 32'h0000_1234);
        cycle();
        InValid = 1'b0;
        repeat (10) cycle();
        check_now("busy_before_rst", W'(MDBusy), 1);
        InValid = 1'b1;
        Op = OP_MFHI;
        Reset = 1'b1;
        #1;
        check_now("midrst_busy", W'(MDBusy), 0);
        check_now("midrst_stall", W'(Stall), 0);
        check_now("midrst_hi", ALUResult, 0);
        Op = OP_MFLO;
        #1;
        check_now("midrst_lo", ALUResult, 0);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        InValid = 1'b0;
        push_exp("postrst_busy", S_BUSY, 0);
        cycle();

        // Flush squashes a MULT
        drive(OP_MULT, 32'd3, 32'd4);
        Flush = 1'b1;
        push_exp("flush_ov", S_OV, 0);
        push_exp("flush_rw", S_RW, 0);
        cycle();
        Flush = 1'b0;
        InValid = 1'b0;
        push_exp("flush_busy", S_BUSY, 0);
        cycle();

`ifdef EX_DIV_EN
        drive(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        push_exp("div_ov", S_OV, 1);
        push_exp("div_rw", S_RW, 0);
        cycle();
        drive(OP_MFLO, 0, 0);
        wait_accept(stalls);
        check_now("div_stalls", stalls, 32);
        push_exp("div_lo", S_RES, 32'hFFFF_FFFD);
        check_pending();
        @(posedge Clock);
        #1;
        drive(OP_MFHI, 0, 0);
        push_exp("div_hi", S_RES, 32'hFFFF_FFFF);
        cycle();
        drive(OP_DIVU, 32'd5, 32'd0);
        cycle();
        drive(OP_MFLO, 0, 0);
        wait_accept(stalls);
        push_exp("divu0_lo", S_RES, 32'hFFFF_FFFF);
        check_pending();
        @(posedge Clock);
        #1;
        drive(OP_MFHI, 0, 0);
        push_exp("divu0_hi", S_RES, 32'd5);
        cycle();
`else
        drive(OP_MTHI, 32'hA5A5_A5A5, 0);
        cycle();
        drive(OP_MTLO, 32'h5A5A_5A5A, 0);
        cycle();
        drive(OP_DIV, 32'd100, 32'd7);
        push_exp("nodiv_ov", S_OV, 1);
        push_exp("nodiv_rw", S_RW, 0);
        cycle();
        InValid = 1'b0;
        push_exp("nodiv_busy", S_BUSY, 0);
        cycle();
        drive(OP_MFHI, 0, 0);
        push_exp("nodiv_hi", S_RES, 32'hA5A5_A5A5);
        cycle();
        drive(OP_MFLO, 0, 0);
        push_exp("nodiv_lo", S_RES, 32'h5A5A_5A5A);
        cycle();
`endif

        InValid = 1'b0;
        cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
